// File: rtl/led_blink_pkg.sv
// Shared definitions for the multi-channel LED blinker: mode encoding, rate table, lookup.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package led_blink_pkg;

    localparam int RATE_IDX_W = 2;
    localparam int RATE_N     = 1 << RATE_IDX_W;

    // Channel operating modes as seen on the cfg_mode write field
    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_FLASH = 2'd3
    } mode_e;

    // Default half-period counts (50 MHz core clock)
    localparam int RATE0_DEF = 50000000;
    localparam int RATE1_DEF = 2500000;
    localparam int RATE2_DEF = 100000000;
    localparam int RATE3_DEF = 16666666;

    // Rate table, entry n holds the half-period count for rate index n
    typedef logic [RATE_N-1:0][31:0] rate_tbl_t;

    localparam rate_tbl_t RATE_TBL_DEF = {
        32'(RATE3_DEF), 32'(RATE2_DEF), 32'(RATE1_DEF), 32'(RATE0_DEF)
    };

    // Half-period count for a rate index; the table defaults to the board rates
    function automatic logic [31:0] rate_lookup(
        input logic [RATE_IDX_W-1:0] idx,
        input rate_tbl_t             tbl = RATE_TBL_DEF
    );
        return tbl[idx];
    endfunction

endpackage

// File: rtl/led_blink_multi_channel.sv
// One LED channel: mode/rate registers, half-period counter, phase and tick decode.
// Latency: config/restart visible the cycle after the edge; LED/tick decoded from registers only.
// Backpressure: none, writes and restarts are always accepted in the cycle they are presented.
module blink_channel
    import led_blink_pkg::*;
#(
    parameter int        CNT_W = 27,
    parameter rate_tbl_t RATES = RATE_TBL_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  restart_i,
    input  logic                  wr_i,
    input  logic [1:0]            mode_i,
    input  logic [RATE_IDX_W-1:0] rate_i,
    output logic                  led_o,
    output logic                  tick_o
);

    mode_e                 mode_q, mode_d;
    logic [RATE_IDX_W-1:0] rate_q, rate_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  phase_q, phase_d;
    logic                  tick_q, tick_d;

    logic [CNT_W-1:0]      half_per;
    logic [CNT_W-1:0]      flash_lim;
    logic                  counting;

    // Rate values wider than the counter are truncated here; the top rejects
    // any rate that would actually lose bits.
    assign half_per  = CNT_W'(rate_lookup(rate_q, RATES));
    assign flash_lim = half_per >> 3;
    assign counting  = (mode_q == MODE_BLINK) || (mode_q == MODE_FLASH);

    // Next-state: config load, restart, then free-running half-period counter
    always_comb begin
        mode_d  = mode_q;
        rate_d  = rate_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        tick_d  = 1'b0;

        if (wr_i) begin
            mode_d = mode_e'(mode_i);
            rate_d = rate_i;
        end

        if (wr_i || restart_i) begin
            // Restart wins over a pending toggle, so no tick on this edge
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (counting) begin
            // >= rather than == so a counter that somehow overshoots recovers
            if (cnt_q >= half_per) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
                tick_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end
    end

    // State registers; reset brings the channel up blinking at rate 0
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q  <= MODE_BLINK;
            rate_q  <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            rate_q  <= rate_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            tick_q  <= tick_d;
        end
    end

    // LED decode from registered state only; FLASH lights the first eighth of the on-phase
    always_comb begin
        led_o = 1'b0;
        unique case (mode_q)
            MODE_OFF:   led_o = 1'b0;
            MODE_ON:    led_o = 1'b1;
            MODE_BLINK: led_o = phase_q;
            MODE_FLASH: led_o = phase_q && (cnt_q < flash_lim);
            default:    led_o = 1'b0;
        endcase
    end

    // tick is registered on the toggling edge, so it lines up with the new phase
    assign tick_o = tick_q;

endmodule

// File: rtl/led_blink_multi.sv
// Multi-channel LED blinker: per-channel mode/rate set over a one-cycle write port, global SYNC.
// Latency: a write or SYNC takes effect on the cycle after its edge; outputs are register-decoded.
// Backpressure: none, every write is accepted; writes to channels >= NUM_CH are dropped.
module led_blink_multi
    import led_blink_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 27,
    parameter int RATE0  = RATE0_DEF,
    parameter int RATE1  = RATE1_DEF,
    parameter int RATE2  = RATE2_DEF,
    parameter int RATE3  = RATE3_DEF
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              cfg_we,
    input  logic [4:0]        cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [1:0]        cfg_rate,
    input  logic              SYNC,
    output logic [NUM_CH-1:0] LED,
    output logic [NUM_CH-1:0] tick
);

    localparam rate_tbl_t RATE_TBL = {32'(RATE3), 32'(RATE2), 32'(RATE1), 32'(RATE0)};
    localparam longint    CNT_LIM  = longint'(1) << CNT_W;

    // Parameter sanity: channel count, counter width, and every rate must fit the counter
    if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
        $error("led_blink_multi: NUM_CH must be in 1..32");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("led_blink_multi: CNT_W must be in 1..32");
    end
    if (longint'(RATE0) >= CNT_LIM || RATE0 < 0) begin : g_bad_rate0
        $error("led_blink_multi: RATE0 does not fit in CNT_W bits");
    end
    if (longint'(RATE1) >= CNT_LIM || RATE1 < 0) begin : g_bad_rate1
        $error("led_blink_multi: RATE1 does not fit in CNT_W bits");
    end
    if (longint'(RATE2) >= CNT_LIM || RATE2 < 0) begin : g_bad_rate2
        $error("led_blink_multi: RATE2 does not fit in CNT_W bits");
    end
    if (longint'(RATE3) >= CNT_LIM || RATE3 < 0) begin : g_bad_rate3
        $error("led_blink_multi: RATE3 does not fit in CNT_W bits");
    end

    logic              cfg_hit;
    logic [NUM_CH-1:0] wr_sel;

    // Out-of-range channel indices never reach any channel
    assign cfg_hit = cfg_we && ({27'd0, cfg_ch} < 32'(NUM_CH));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_sel[i] = cfg_hit && (cfg_ch == 5'(i));

        blink_channel #(
            .CNT_W (CNT_W),
            .RATES (RATE_TBL)
        ) u_ch (
            .clk_i     (CLOCK_50),
            .rst_i     (RESET),
            .restart_i (SYNC),
            .wr_i      (wr_sel[i]),
            .mode_i    (cfg_mode),
            .rate_i    (cfg_rate),
            .led_o     (LED[i]),
            .tick_o    (tick[i])
        );
    end

endmodule
